// File: rtl/z80_uart.sv
// Memory-mapped 8N1 UART for the z80computer CPU bus: DATA/STATUS registers, cs/we/ack handshake.
// Define UART_RX_FIFO_EN for an RX_FIFO_DEPTH-entry receive FIFO; otherwise a single-byte receive register.
module z80_uart #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_addr,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    input  logic       i_we,
    input  logic       i_cs,
    output logic       o_ack,
    output logic       o_irq,
    output logic       o_tx,
    input  logic       i_rx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    generate
        if (CLKS_PER_BIT < 4 || RX_FIFO_DEPTH < 2) begin : g_bad_param
            $error("z80_uart: CLKS_PER_BIT must be >= 4 and RX_FIFO_DEPTH >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    logic            cs_q;
    logic            access, rd_data, rd_status, wr_data;
    logic            tx_full, tx_accept, tx_load;
    logic [7:0]      tx_hold, tx_shift, tx_shift_nxt;
    tx_state_t       tx_state, tx_state_nxt;
    logic [CW-1:0]   tx_cnt, tx_cnt_nxt;
    logic [2:0]      tx_bit, tx_bit_nxt;
    logic            tx_line_nxt;

    logic            rx_s1, rx_s2, rx_prev;
    rx_state_t       rx_state, rx_state_nxt;
    logic [CW-1:0]   rx_cnt, rx_cnt_nxt;
    logic [2:0]      rx_bit, rx_bit_nxt;
    logic [7:0]      rx_shift, rx_shift_nxt;
    logic            rx_push, ferr_set;

    logic            rx_valid, rx_pop, push_ok, ovr_set;
    logic [7:0]      rx_head;
    logic            ovr, ferr;
    logic [7:0]      status;

    // Side effects only on the first cycle of an access.
    assign access    = i_cs & ~cs_q;
    assign rd_data   = access & ~i_we & ~i_addr;
    assign rd_status = access & ~i_we &  i_addr;
    assign wr_data   = access &  i_we & ~i_addr;
    assign tx_accept = wr_data & ~tx_full;
    assign status    = {4'b0000, ferr, ovr, rx_valid, tx_full};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cs_q    <= 1'b0;
            o_ack   <= 1'b0;
            o_dat   <= 8'h00;
            o_irq   <= 1'b0;
            tx_full <= 1'b0;
            ovr     <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            cs_q  <= i_cs;
            o_ack <= access | (o_ack & i_cs);
            if (rd_data)
                o_dat <= rx_valid ? rx_head : 8'h00;
            else if (rd_status)
                o_dat <= status;
            if (tx_load)
                tx_full <= 1'b0;
            else if (tx_accept)
                tx_full <= 1'b1;
            ovr   <= ovr_set  | (ovr  & ~rd_status);
            ferr  <= ferr_set | (ferr & ~rd_status);
            o_irq <= rx_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (tx_accept)
            tx_hold <= i_dat;
        tx_shift <= tx_shift_nxt;
        rx_shift <= rx_shift_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        tx_load      = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (tx_full) begin
                    tx_state_nxt = TX_START;
                    tx_load      = 1'b1;
                    tx_shift_nxt = tx_hold;
                    tx_cnt_nxt   = '0;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_nxt = TX_DATA;
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = 3'd0;
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = TX_STOP;
                    end else begin
                        tx_bit_nxt   = tx_bit + 1'b1;
                        tx_shift_nxt = {1'b1, tx_shift[7:1]};
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt = '0;
                    // A queued byte starts immediately, with no idle bit between frames.
                    if (tx_full) begin
                        tx_state_nxt = TX_START;
                        tx_load      = 1'b1;
                        tx_shift_nxt = tx_hold;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
        tx_line_nxt = 1'b1;
        if (tx_state_nxt == TX_START)
            tx_line_nxt = 1'b0;
        else if (tx_state_nxt == TX_DATA)
            tx_line_nxt = tx_shift_nxt[0];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            o_tx     <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            o_tx     <= tx_line_nxt;
        end
    end

    // START counts from the cycle after the falling edge is seen, so HALF_LAST lands mid-bit.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_push      = 1'b0;
        ferr_set     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s2) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_bit_nxt   = 3'd0;
                    rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_s2, rx_shift[7:1]};
                    if (rx_bit == 3'd7)
                        rx_state_nxt = RX_STOP;
                    else
                        rx_bit_nxt = rx_bit + 1'b1;
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt = '0;
                    if (rx_s2) begin
                        rx_push      = 1'b1;
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        ferr_set     = 1'b1;
                        rx_state_nxt = RX_BREAK;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            RX_BREAK: begin
                if (rx_s2)
                    rx_state_nxt = RX_IDLE;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
        end else begin
            rx_s1    <= i_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
        end
    end

    // A pop in the same cycle frees a slot, so push and pop may both happen when full.
    assign rx_pop  = rd_data & rx_valid;
    assign ovr_set = rx_push & ~push_ok;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);

    logic [7:0] rx_mem [RX_FIFO_DEPTH];
    logic [AW:0] rx_wptr, rx_rptr;
    logic        rx_full;

    assign rx_full  = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
    assign rx_valid = (rx_wptr != rx_rptr);
    assign rx_head  = rx_mem[rx_rptr[AW-1:0]];
    assign push_ok  = rx_push & (~rx_full | rx_pop);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (push_ok)
                rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)
                rx_rptr <= rx_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok)
            rx_mem[rx_wptr[AW-1:0]] <= rx_shift;
    end
`else
    logic [7:0] rx_data;
    logic       rx_full_q;

    assign rx_valid = rx_full_q;
    assign rx_head  = rx_data;
    assign push_ok  = rx_push & (~rx_full_q | rx_pop);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            rx_full_q <= 1'b0;
        else
            rx_full_q <= push_ok | (rx_full_q & ~rx_pop);
    end

    always_ff @(posedge i_clk) begin
        if (push_ok)
            rx_data <= rx_shift;
    end
`endif

endmodule
